perf_counter_bank: RTL and testbench

- Parametrised, memory-mapped bank of event counters for the pipeline's MEM stage.
- Generalises the stage's fixed set of 10-bit hit/miss/stall counters:
  - configurable channel count and counter width;
  - saturate or wrap mode with sticky overflow flags;
  - global freeze and clear;
  - preset-by-store;
  - registered read path with a one-cycle response handshake.
- The MEM stage uses `hit` to suppress the real memory access whenever `addr` falls in the counter window.

---
 rtl/perf_counter_bank_if.sv | 22 ++
 rtl/perf_counter_bank.sv | 146 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_bank_if.sv
// Memory-mapped access bus for the MEM-stage performance counter bank.
// The master drives the address and strobes; the counter bank answers with hit, read data and a response pulse.
interface perf_counter_bank_if;
    logic [15:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] wdata;
    logic        hit;
    logic [15:0] rdata;
    logic        resp;
    logic        busy;

    modport master (
        output addr, rd_req, wr_req, wdata,
        input  hit, rdata, resp, busy
    );

    modport slave (
        input  addr, rd_req, wr_req, wdata,
        output hit, rdata, resp, busy
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Parametrised bank of event counters with a CTRL and a STATUS register.
// Counters can saturate or wrap, and a read path with a one-cycle response.
module perf_counter_bank #(
    parameter int          NUM_CH      = 9,
    parameter int          CNT_WIDTH   = 10,
    parameter logic [15:0] TOP_ADDR    = 16'hFFFF,
    parameter logic        SAT_DEFAULT = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   event_in,
    perf_counter_bank_if.slave  bus,
    output logic                overflow_any
);

    localparam logic [15:0] CTRL_ADDR   = TOP_ADDR - 16'(2 * NUM_CH);
    localparam logic [15:0] STATUS_ADDR = TOP_ADDR - 16'(2 * (NUM_CH + 1));

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0]    overflow;
    logic [NUM_CH-1:0]    ch_sel;
    logic [NUM_CH-1:0]    wrap;
    logic                 freeze;
    logic                 sat;
    logic                 sel_ctrl;
    logic                 sel_status;
    logic                 accept;
    logic                 wr_en;
    logic                 rd_en;
    logic                 clear_all;
    logic [15:0]          rd_mux;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (bus.addr == 16'(TOP_ADDR - 16'(2 * i)));
        end
    end

    assign sel_ctrl     = (bus.addr == CTRL_ADDR);
    assign sel_status   = (bus.addr == STATUS_ADDR);
    assign bus.hit      = (|ch_sel) | sel_ctrl | sel_status;
    assign accept       = (state == IDLE) && (bus.rd_req || bus.wr_req) && bus.hit;
    assign wr_en        = accept && bus.wr_req;
    assign rd_en        = accept && bus.rd_req;
    assign clear_all    = wr_en && sel_ctrl && bus.wdata[1];
    assign overflow_any = |overflow;

    // A wrap only counts when neither clear_all nor a store to the channel overrides the increment.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i] = event_in[i] && !freeze && !sat && (&cnt[i])
                      && !clear_all && !(wr_en && ch_sel[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear_all) begin
                    cnt[i] <= '0;
                end else if (wr_en && ch_sel[i]) begin
                    cnt[i] <= bus.wdata[CNT_WIDTH-1:0];
                end else if (event_in[i] && !freeze && !(sat && (&cnt[i]))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A wrap on the same edge as a write-1-to-clear keeps its flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= '0;
        end else if (clear_all) begin
            overflow <= '0;
        end else if (wr_en && sel_status) begin
            overflow <= (overflow & ~bus.wdata[NUM_CH-1:0]) | wrap;
        end else begin
            overflow <= overflow | wrap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freeze <= 1'b0;
            sat    <= SAT_DEFAULT;
        end else if (wr_en && sel_ctrl) begin
            freeze <= bus.wdata[0];
            sat    <= bus.wdata[2];
        end
    end

    always_comb begin
        rd_mux = '0;
        if (sel_ctrl) begin
            rd_mux = {13'd0, sat, 1'b0, freeze};
        end else if (sel_status) begin
            rd_mux = 16'(overflow);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel[i]) begin
                    rd_mux = 16'(cnt[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rdata <= '0;
        end else if (rd_en) begin
            bus.rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.resp = (state == RESP);
        bus.busy = (state == RESP);
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: an arithmetic model of the register map is compared
// every cycle, alongside hand-computed expectations from the test plan.
module tb_perf_counter_bank;

    localparam int NUM_CH    = 9;
    localparam int CNT_WIDTH = 10;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
    localparam int TOP       = 16'hFFFF;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] event_in = '0;
    logic              overflow_any;
    int                errors = 0;
    int                checks = 0;
    logic              compare_en = 1'b0;

    int                m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_ovf;
    logic              m_freeze;
    logic              m_sat;
    logic [15:0]       m_rdata;
    logic              m_busy;

    perf_counter_bank_if bus ();

    perf_counter_bank #(
        .NUM_CH     (NUM_CH),
        .CNT_WIDTH  (CNT_WIDTH),
        .TOP_ADDR   (16'hFFFF),
        .SAT_DEFAULT(1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .event_in    (event_in),
        .bus         (bus.slave),
        .overflow_any(overflow_any)
    );

    always #5 clk = ~clk;

    // Register index counted downward from the top address; -1 means not in the map.
    function automatic int reg_index(input logic [15:0] a);
        int off;
        off = TOP - int'(a);
        if (off % 2 != 0 || off > 2 * (NUM_CH + 1)) return -1;
        return off / 2;
    endfunction

    function automatic logic model_hit(input logic [15:0] a);
        return reg_index(a) >= 0;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int idx;
        idx = reg_index(a);
        if (idx == NUM_CH) return {13'd0, m_sat, 1'b0, m_freeze};
        if (idx == NUM_CH + 1) return 16'(m_ovf);
        return 16'(m_cnt[idx]);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] <= 0;
            m_ovf    <= '0;
            m_freeze <= 1'b0;
            m_sat    <= 1'b1;
            m_rdata  <= '0;
            m_busy   <= 1'b0;
        end else begin
            automatic logic              acc   = !m_busy && (bus.rd_req || bus.wr_req) && model_hit(bus.addr);
            automatic int                idx   = reg_index(bus.addr);
            automatic logic              wr    = acc && bus.wr_req;
            automatic logic              clear = wr && idx == NUM_CH && bus.wdata[1];
            automatic logic [NUM_CH-1:0] wraps = '0;
            automatic logic [NUM_CH-1:0] ovf_n = m_ovf;
            automatic int                n_cnt [NUM_CH];
            for (int i = 0; i < NUM_CH; i++) begin
                n_cnt[i] = m_cnt[i];
                if (clear) n_cnt[i] = 0;
                else if (wr && idx == i) n_cnt[i] = int'(bus.wdata) % (CNT_MAX + 1);
                else if (event_in[i] && !m_freeze) begin
                    if (m_cnt[i] < CNT_MAX) n_cnt[i] = m_cnt[i] + 1;
                    else if (!m_sat) begin
                        n_cnt[i] = 0;
                        wraps[i] = 1'b1;
                    end
                end
            end
            if (clear) ovf_n = '0;
            else begin
                if (wr && idx == NUM_CH + 1) ovf_n = ovf_n & ~bus.wdata[NUM_CH-1:0];
                ovf_n = ovf_n | wraps;
            end
            if (acc && bus.rd_req) m_rdata <= model_read(bus.addr);
            if (wr && idx == NUM_CH) begin
                m_freeze <= bus.wdata[0];
                m_sat    <= bus.wdata[2];
            end
            for (int i = 0; i < NUM_CH; i++) m_cnt[i] <= n_cnt[i];
            m_ovf  <= ovf_n;
            m_busy <= acc;
        end
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (compare_en) begin
            check_output("model_hit",      16'(bus.hit),      16'(model_hit(bus.addr)));
            check_output("model_resp",     16'(bus.resp),     16'(m_busy));
            check_output("model_busy",     16'(bus.busy),     16'(m_busy));
            check_output("model_rdata",    bus.rdata,         m_rdata);
            check_output("model_overflow", 16'(overflow_any), 16'(|m_ovf));
        end
    end

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] a,
                                  input logic [15:0] d, input logic [NUM_CH-1:0] ev);
        @(negedge clk);
        bus.rd_req = rd;
        bus.wr_req = wr;
        bus.addr   = a;
        bus.wdata  = d;
        event_in   = ev;
    endtask

    task automatic idle_cycles(input int n, input logic [NUM_CH-1:0] ev);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000, ev);
    endtask

    task automatic write_reg(input logic [15:0] a, input logic [15:0] d);
        apply_stimulus(1'b0, 1'b1, a, d, '0);
        idle_cycles(1, '0);
    endtask

    task automatic read_reg(input string name, input logic [15:0] a, input logic [15:0] expected);
        apply_stimulus(1'b1, 1'b0, a, 16'h0000, '0);
        check_output({name, "_resp_before"}, 16'(bus.resp), 16'h0000);
        idle_cycles(1, '0);
        check_output({name, "_resp"}, 16'(bus.resp), 16'h0001);
        check_output(name, bus.rdata, expected);
    endtask

    initial begin
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        bus.addr   = 16'h0000;
        bus.wdata  = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        compare_en = 1'b1;
        check_output("reset_rdata", bus.rdata, 16'h0000);
        check_output("reset_busy", 16'(bus.busy), 16'h0000);
        check_output("reset_overflow", 16'(overflow_any), 16'h0000);

        // Reset and read
        idle_cycles(5, 9'h001);
        read_reg("ch0_after_5", 16'hFFFF, 16'h0005);
        read_reg("ctrl_default", 16'hFFED, 16'h0004);

        // Saturate versus wrap
        write_reg(16'hFFFD, 16'h03FE);
        idle_cycles(3, 9'h002);
        read_reg("ch1_saturated", 16'hFFFD, 16'h03FF);
        check_output("no_overflow_sat", 16'(overflow_any), 16'h0000);
        write_reg(16'hFFED, 16'h0000);
        write_reg(16'hFFFD, 16'h03FF);
        idle_cycles(1, 9'h002);
        read_reg("ch1_wrapped", 16'hFFFD, 16'h0000);
        read_reg("status_after_wrap", 16'hFFEB, 16'h0002);
        check_output("overflow_set", 16'(overflow_any), 16'h0001);
        write_reg(16'hFFEB, 16'h0002);
        check_output("overflow_w1c", 16'(overflow_any), 16'h0000);

        // Freeze and clear_all
        write_reg(16'hFFED, 16'h0006);
        idle_cycles(4, 9'h1FF);
        write_reg(16'hFFED, 16'h0005);
        idle_cycles(3, 9'h1FF);
        for (int i = 0; i < NUM_CH; i++) read_reg("frozen_ch", 16'(TOP - 2 * i), 16'h0004);
        write_reg(16'hFFED, 16'h0002);
        for (int i = 0; i < NUM_CH; i++) read_reg("cleared_ch", 16'(TOP - 2 * i), 16'h0000);
        read_reg("ctrl_after_clear", 16'hFFED, 16'h0000);
        write_reg(16'hFFED, 16'h0004);

        // Collisions
        idle_cycles(2, 9'h004);
        apply_stimulus(1'b0, 1'b1, 16'hFFFB, 16'h0000, 9'h004);
        idle_cycles(1, '0);
        read_reg("ch2_store_wins", 16'hFFFB, 16'h0000);
        idle_cycles(3, 9'h004);
        apply_stimulus(1'b1, 1'b1, 16'hFFFB, 16'h0007, '0);
        idle_cycles(1, '0);
        check_output("rdwr_old_value", bus.rdata, 16'h0003);
        read_reg("ch2_after_rdwr", 16'hFFFB, 16'h0007);

        // Decode misses and strobes while busy
        apply_stimulus(1'b1, 1'b0, 16'hFFFE, 16'h0000, '0);
        check_output("miss_fffe_hit", 16'(bus.hit), 16'h0000);
        idle_cycles(1, '0);
        check_output("miss_fffe_resp", 16'(bus.resp), 16'h0000);
        apply_stimulus(1'b0, 1'b1, 16'hFFE9, 16'h0001, '0);
        check_output("miss_ffe9_hit", 16'(bus.hit), 16'h0000);
        idle_cycles(1, '0);
        check_output("miss_ffe9_resp", 16'(bus.resp), 16'h0000);
        apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, '0);
        apply_stimulus(1'b0, 1'b1, 16'hFFFF, 16'h0055, '0);
        check_output("busy_during_resp", 16'(bus.busy), 16'h0001);
        idle_cycles(1, '0);
        check_output("no_second_resp", 16'(bus.resp), 16'h0000);
        read_reg("ch0_unchanged", 16'hFFFF, 16'h0000);

        // Asynchronous reset during a response
        idle_cycles(4, 9'h001);
        apply_stimulus(1'b1, 1'b0, 16'hFFFF, 16'h0000, '0);
        idle_cycles(1, '0);
        check_output("resp_before_reset", 16'(bus.resp), 16'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("resp_async_drop", 16'(bus.resp), 16'h0000);
        check_output("busy_async_drop", 16'(bus.busy), 16'h0000);
        idle_cycles(2, '0);
        reset_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) read_reg("post_reset_ch", 16'(TOP - 2 * i), 16'h0000);
        read_reg("post_reset_ctrl", 16'hFFED, 16'h0004);
        idle_cycles(2, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
